// File: rtl/ras_pkg.sv
// Shared RAS definitions: stack geometry, checkpoint queue depth, controller FSM state and checkpoint entry layout.
package ras_pkg;

  localparam int unsigned RAS_DEPTH      = 16;
  localparam int unsigned RAS_PTR_W      = 4;
  localparam int unsigned RAS_DATA_W     = 64;
  localparam int unsigned RAS_CKPT_DEPTH = 8;
  localparam int unsigned RAS_CKPT_TAG_W = $clog2(RAS_CKPT_DEPTH);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REPAIR = 1'b1
  } ras_ckpt_state_e;

  typedef struct packed {
    logic [RAS_PTR_W-1:0]  ptr;
    logic [RAS_DATA_W-1:0] tos;
  } ras_ckpt_entry_t;

endpackage

// File: rtl/ras_ckpt_ctrl_if.sv
// Fetch/execute/retire <-> RAS checkpoint controller signal bundle; slave is the controller side.
interface ras_ckpt_ctrl_if
  import ras_pkg::*;
#(
  parameter int unsigned TAG_W  = RAS_CKPT_TAG_W,
  parameter int unsigned PTR_W  = RAS_PTR_W,
  parameter int unsigned DATA_W = RAS_DATA_W
);

  logic              alloc_valid_i;
  logic              alloc_ready_o;
  logic [PTR_W-1:0]  alloc_ptr_i;
  logic [DATA_W-1:0] alloc_tos_i;
  logic [TAG_W-1:0]  alloc_tag_o;
  logic              commit_valid_i;
  logic              mispred_valid_i;
  logic [TAG_W-1:0]  mispred_tag_i;
  logic              flush_rt_i;
  logic              ras_restore_valid_o;
  logic [PTR_W-1:0]  ras_restore_ptr_o;
  logic              ras_repair_we_o;
  logic [PTR_W-1:0]  ras_repair_idx_o;
  logic [DATA_W-1:0] ras_repair_data_o;
  logic [PTR_W-1:0]  ras_ptr_rt_o;
  logic              fetch_stall_o;
  logic [TAG_W:0]    count_o;

  modport slave (
    input  alloc_valid_i, alloc_ptr_i, alloc_tos_i,
    input  commit_valid_i, mispred_valid_i, mispred_tag_i, flush_rt_i,
    output alloc_ready_o, alloc_tag_o,
    output ras_restore_valid_o, ras_restore_ptr_o,
    output ras_repair_we_o, ras_repair_idx_o, ras_repair_data_o,
    output ras_ptr_rt_o, fetch_stall_o, count_o
  );

  modport master (
    output alloc_valid_i, alloc_ptr_i, alloc_tos_i,
    output commit_valid_i, mispred_valid_i, mispred_tag_i, flush_rt_i,
    input  alloc_ready_o, alloc_tag_o,
    input  ras_restore_valid_o, ras_restore_ptr_o,
    input  ras_repair_we_o, ras_repair_idx_o, ras_repair_data_o,
    input  ras_ptr_rt_o, fetch_stall_o, count_o
  );

endinterface

// File: rtl/ras_ckpt_ram.sv
// Checkpoint register file: one write port (tail), read ports for commit (head) and mispredict (tag).
// Top-of-stack storage exists only when RAS_CKPT_REPAIR_EN is defined.
module ras_ckpt_ram #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned TAG_W  = 3,
  parameter int unsigned PTR_W  = 4,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [TAG_W-1:0]  i_waddr,
  input  logic [PTR_W-1:0]  i_wptr,
  input  logic [DATA_W-1:0] i_wtos,
  input  logic [TAG_W-1:0]  i_raddr0,
  output logic [PTR_W-1:0]  o_rptr0,
  input  logic [TAG_W-1:0]  i_raddr1,
  output logic [PTR_W-1:0]  o_rptr1,
  output logic [DATA_W-1:0] o_rtos1
);

  logic [PTR_W-1:0] r_ptr [DEPTH];

  // Entries are only read while live, so the array needs no reset
  always_ff @(posedge clk) begin
    if (i_we) r_ptr[i_waddr] <= i_wptr;
  end

  assign o_rptr0 = r_ptr[i_raddr0];
  assign o_rptr1 = r_ptr[i_raddr1];

`ifdef RAS_CKPT_REPAIR_EN
  logic [DATA_W-1:0] r_tos [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_tos[i_waddr] <= i_wtos;
  end

  assign o_rtos1 = r_tos[i_raddr1];
`else
  logic w_unused_tos;

  assign w_unused_tos = ^i_wtos;
  assign o_rtos1      = '0;
`endif

endmodule

// File: rtl/ras_ckpt_ctrl.sv
// RAS checkpoint/recovery controller: checkpoints RAS state per in-flight branch, restores it on
// mispredict or retire flush. RAS_CKPT_REPAIR_EN adds the top-of-stack repair write and REPAIR state.
module ras_ckpt_ctrl
  import ras_pkg::*;
#(
  parameter int unsigned DEPTH  = RAS_CKPT_DEPTH,
  parameter int unsigned TAG_W  = $clog2(DEPTH),
  parameter int unsigned PTR_W  = RAS_PTR_W,
  parameter int unsigned DATA_W = RAS_DATA_W
) (
  input logic            clock,
  input logic            reset_n,
  ras_ckpt_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = TAG_W + 1;

  logic [CNT_W-1:0]  r_head;
  logic [CNT_W-1:0]  r_tail;
  logic [PTR_W-1:0]  r_ptr_rt;
  logic              r_restore_valid;
  logic [PTR_W-1:0]  r_restore_ptr;
  logic              r_stall;

  logic [CNT_W-1:0]  w_count;
  logic              w_empty;
  logic              w_full;
  logic              w_ready;
  logic [TAG_W-1:0]  w_tag_off;
  logic [CNT_W-1:0]  w_mis_new_tail;
  logic              w_mis_live;
  logic              w_mis_acc;
  logic              w_commit;
  logic              w_alloc;
  logic              w_restore_nxt;
  logic              w_stall_nxt;
  logic [PTR_W-1:0]  w_ptr_rt_nxt;
  logic [PTR_W-1:0]  w_rd_head_ptr;
  logic [PTR_W-1:0]  w_rd_tag_ptr;
  logic [DATA_W-1:0] w_rd_tag_tos;

  assign w_count = r_tail - r_head;
  assign w_empty = (r_head == r_tail);
  assign w_full  = (r_head[TAG_W] != r_tail[TAG_W]) &&
                   (r_head[TAG_W-1:0] == r_tail[TAG_W-1:0]);

  // A tag is live when its distance from head is below the occupancy
  assign w_tag_off      = TAG_W'(bus.mispred_tag_i - r_head[TAG_W-1:0]);
  assign w_mis_live     = bus.mispred_valid_i && ({1'b0, w_tag_off} < w_count);
  assign w_mis_new_tail = r_head + {1'b0, w_tag_off} + CNT_W'(1);
  assign w_mis_acc      = w_mis_live && !bus.flush_rt_i;

  assign w_commit      = bus.commit_valid_i && !w_empty;
  assign w_alloc       = bus.alloc_valid_i && w_ready && !bus.flush_rt_i && !bus.mispred_valid_i;
  assign w_ptr_rt_nxt  = w_commit ? w_rd_head_ptr : r_ptr_rt;
  assign w_restore_nxt = bus.flush_rt_i || w_mis_acc;

  ras_ckpt_ram #(
    .DEPTH  (DEPTH),
    .TAG_W  (TAG_W),
    .PTR_W  (PTR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk      (clock),
    .i_we     (w_alloc),
    .i_waddr  (r_tail[TAG_W-1:0]),
    .i_wptr   (bus.alloc_ptr_i),
    .i_wtos   (bus.alloc_tos_i),
    .i_raddr0 (r_head[TAG_W-1:0]),
    .o_rptr0  (w_rd_head_ptr),
    .i_raddr1 (bus.mispred_tag_i),
    .o_rptr1  (w_rd_tag_ptr),
    .o_rtos1  (w_rd_tag_tos)
  );

  // Queue pointers; a mispredict rewinds tail to just past the offending branch
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (bus.flush_rt_i) begin
      r_head <= r_tail;
    end else begin
      if (w_commit) r_head <= r_head + CNT_W'(1);
      if (w_mis_acc)    r_tail <= w_mis_new_tail;
      else if (w_alloc) r_tail <= r_tail + CNT_W'(1);
    end
  end

  // Committed pointer and restore pulse; a flush restores the post-commit value
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr_rt        <= '0;
      r_restore_valid <= 1'b0;
      r_restore_ptr   <= '0;
      r_stall         <= 1'b0;
    end else begin
      r_ptr_rt        <= w_ptr_rt_nxt;
      r_restore_valid <= w_restore_nxt;
      r_stall         <= w_stall_nxt;
      if (bus.flush_rt_i)  r_restore_ptr <= w_ptr_rt_nxt;
      else if (w_mis_acc)  r_restore_ptr <= w_rd_tag_ptr;
      else                 r_restore_ptr <= '0;
    end
  end

`ifdef RAS_CKPT_REPAIR_EN
  ras_ckpt_state_e   r_state;
  ras_ckpt_state_e   w_state_nxt;
  logic              w_repair_we_nxt;
  logic [DATA_W-1:0] r_rep_tos;
  logic              r_repair_we;
  logic [PTR_W-1:0]  r_repair_idx;
  logic [DATA_W-1:0] r_repair_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // REPAIR coincides with the restore cycle; the write issues as it exits unless superseded
  always_comb begin
    w_state_nxt     = r_state;
    w_repair_we_nxt = 1'b0;
    if (bus.flush_rt_i) begin
      w_state_nxt = IDLE;
    end else if (w_mis_acc) begin
      w_state_nxt = REPAIR;
    end else if (r_state == REPAIR) begin
      w_state_nxt     = IDLE;
      w_repair_we_nxt = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rep_tos     <= '0;
      r_repair_we   <= 1'b0;
      r_repair_idx  <= '0;
      r_repair_data <= '0;
    end else begin
      if (w_mis_acc) r_rep_tos <= w_rd_tag_tos;
      r_repair_we   <= w_repair_we_nxt;
      r_repair_idx  <= w_repair_we_nxt ? r_restore_ptr : '0;
      r_repair_data <= w_repair_we_nxt ? r_rep_tos : '0;
    end
  end

  assign w_ready     = (r_state == IDLE) && !w_full;
  assign w_stall_nxt = w_restore_nxt || w_repair_we_nxt;

  assign bus.ras_repair_we_o   = r_repair_we;
  assign bus.ras_repair_idx_o  = r_repair_idx;
  assign bus.ras_repair_data_o = r_repair_data;
`else
  logic w_unused_tos;

  assign w_unused_tos = ^w_rd_tag_tos;
  assign w_ready      = !w_full;
  assign w_stall_nxt  = w_restore_nxt;

  assign bus.ras_repair_we_o   = 1'b0;
  assign bus.ras_repair_idx_o  = '0;
  assign bus.ras_repair_data_o = '0;
`endif

  assign bus.alloc_ready_o       = w_ready;
  assign bus.alloc_tag_o         = r_tail[TAG_W-1:0];
  assign bus.count_o             = w_count;
  assign bus.ras_restore_valid_o = r_restore_valid;
  assign bus.ras_restore_ptr_o   = r_restore_ptr;
  assign bus.ras_ptr_rt_o        = r_ptr_rt;
  assign bus.fetch_stall_o       = r_stall;

endmodule

// File: tb/tb_ras_ckpt_ctrl.sv
// Scoreboard bench for ras_ckpt_ctrl: directed scenarios then random traffic against a queue-based
// model of the checkpoint list; follows RAS_CKPT_REPAIR_EN like the design.
module tb_ras_ckpt_ctrl;
  import ras_pkg::*;

  localparam int unsigned DEPTH  = RAS_CKPT_DEPTH;
  localparam int unsigned TAG_W  = RAS_CKPT_TAG_W;
  localparam int unsigned PTR_W  = RAS_PTR_W;
  localparam int unsigned DATA_W = RAS_DATA_W;
`ifdef RAS_CKPT_REPAIR_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  typedef struct {
    int              cnt;
    bit              rdy;
    int              rt;
    bit              stall;
    bit              rv;
    int              rptr;
    bit              we;
    int              widx;
    longint unsigned wdata;
    int              tag;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  ras_ckpt_ctrl_if #(.TAG_W(TAG_W), .PTR_W(PTR_W), .DATA_W(DATA_W)) bus ();

  ras_ckpt_ctrl #(
    .DEPTH  (DEPTH),
    .TAG_W  (TAG_W),
    .PTR_W  (PTR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Reference model: ordered list of live checkpoints with their tags
  ras_ckpt_entry_t m_ent[$];
  int              m_tag[$];
  int              m_tail = 0;
  int              m_rt   = 0;
  bit              m_busy = 1'b0;
  ras_ckpt_entry_t m_pend;
  exp_t            exp_q[$];

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.cnt  = m_ent.size();
    e.rdy  = (m_ent.size() < DEPTH) && !m_busy;
    e.rt   = m_rt;
    e.tag  = m_tail;
    e.stall = 1'b0; e.rv = 1'b0; e.rptr = 0; e.we = 1'b0; e.widx = 0; e.wdata = 0;
    return e;
  endfunction

  task automatic model_step(input bit av, input ras_ckpt_entry_t a, input bit cv,
                            input bit mv, input int mt, input bit fl);
    exp_t            e;
    bit              live = 1'b0;
    bit              afire;
    int              k = -1;
    ras_ckpt_entry_t ent = '0;
    bit              was_busy = m_busy;
    for (int i = 0; i < m_tag.size(); i++)
      if (mv && m_tag[i] == mt) begin live = 1'b1; ent = m_ent[i]; end
    afire = av && (m_ent.size() < DEPTH) && !m_busy && !fl && !mv;
    if (cv && m_ent.size() > 0) begin
      m_rt = int'(m_ent[0].ptr);
      void'(m_ent.pop_front());
      void'(m_tag.pop_front());
    end
    m_busy = 1'b0;
    if (fl) begin
      m_ent.delete();
      m_tag.delete();
    end else if (live) begin
      for (int i = 0; i < m_tag.size(); i++) if (m_tag[i] == mt) k = i;
      while (m_ent.size() > k + 1) begin
        void'(m_ent.pop_back());
        void'(m_tag.pop_back());
      end
      m_tail = (mt + 1) % DEPTH;
    end else if (afire) begin
      m_ent.push_back(a);
      m_tag.push_back(m_tail);
      m_tail = (m_tail + 1) % DEPTH;
    end
    e = snapshot();
    e.rv    = fl || live;
    e.rptr  = fl ? m_rt : int'(ent.ptr);
    e.we    = REP && was_busy && !fl && !live;
    e.widx  = int'(m_pend.ptr);
    e.wdata = m_pend.tos;
    if (REP && live && !fl) begin
      m_busy = 1'b1;
      m_pend = ent;
    end
    e.rdy   = (m_ent.size() < DEPTH) && !m_busy;
    e.stall = e.rv || e.we;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit av, input int p, input longint unsigned t, input bit cv,
                     input bit mv, input int mt, input bit fl);
    ras_ckpt_entry_t a;
    a.ptr = PTR_W'(p);
    a.tos = t;
    bus.alloc_valid_i   = av;
    bus.alloc_ptr_i     = a.ptr;
    bus.alloc_tos_i     = a.tos;
    bus.commit_valid_i  = cv;
    bus.mispred_valid_i = mv;
    bus.mispred_tag_i   = TAG_W'(mt);
    bus.flush_rt_i      = fl;
    model_step(av, a, cv, mv, mt % DEPTH, fl);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alloc(input int p, input longint unsigned t);
    cyc(1, p, t, 0, 0, 0, 0);
  endtask

  task automatic mis(input int tg);
    cyc(0, 0, 0, 0, 1, tg, 0);
  endtask

  // Monitor: one expected status per cycle, sampled mid-cycle
  always @(negedge clock) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        chk("exp_queue_empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("count_o", bus.count_o, e.cnt);
        chk("alloc_ready_o", bus.alloc_ready_o, e.rdy);
        chk("ras_ptr_rt_o", bus.ras_ptr_rt_o, e.rt);
        chk("fetch_stall_o", bus.fetch_stall_o, e.stall);
        chk("ras_restore_valid_o", bus.ras_restore_valid_o, e.rv);
        chk("ras_repair_we_o", bus.ras_repair_we_o, e.we);
        if (e.rv) chk("ras_restore_ptr_o", bus.ras_restore_ptr_o, e.rptr);
        if (e.we) begin
          chk("ras_repair_idx_o", bus.ras_repair_idx_o, e.widx);
          chk("ras_repair_data_o", bus.ras_repair_data_o, e.wdata);
        end
        if (bus.alloc_valid_i && bus.alloc_ready_o) chk("alloc_tag_o", bus.alloc_tag_o, e.tag);
      end
    end
  end

  initial begin
    int base;
    int youngest;
    bit av, cv, mv, fl;
    int mt;
    reset_n             = 1'b0;
    bus.alloc_valid_i   = 1'b0;
    bus.alloc_ptr_i     = '0;
    bus.alloc_tos_i     = '0;
    bus.commit_valid_i  = 1'b0;
    bus.mispred_valid_i = 1'b0;
    bus.mispred_tag_i   = '0;
    bus.flush_rt_i      = 1'b0;
    m_pend              = '0;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    exp_q.push_back(snapshot());
    mon_en = 1'b1;
    idle(2);

    // Fill to capacity; the ninth request must be refused
    for (int i = 1; i <= 9; i++) alloc(i, 64'h100 + i);
    idle(1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    idle(2);

    // Commit path, including a commit on an empty queue
    alloc(3, 64'h33);
    alloc(4, 64'h44);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    idle(1);

    // Mispredict on the second of four checkpoints
    base = m_tail;
    alloc(2, 64'hAAAA_AAAA_0000_000A);
    alloc(3, 64'hBBBB_BBBB_0000_000B);
    alloc(4, 64'hCCCC_CCCC_0000_000C);
    alloc(5, 64'hDDDD_DDDD_0000_000D);
    mis((base + 1) % DEPTH);
    idle(3);
    alloc(9, 64'h99);
    idle(1);

    // Mispredict in the repair window on an older live tag, then a dead tag
    alloc(6, 64'h6666);
    alloc(7, 64'h7777);
    youngest = (m_tail + DEPTH - 1) % DEPTH;
    mis(youngest);
    mis(m_tag[0]);
    idle(3);
    mis(m_tail);
    idle(2);

    // Flush with a same-cycle mispredict and alloc, and a flush aborting a repair
    alloc(8, 64'h8888);
    alloc(10, 64'hAAAA);
    cyc(1, 11, 64'hBBBB, 0, 1, m_tag[0], 1);
    idle(3);
    alloc(12, 64'hCCCC);
    alloc(13, 64'hDDDD);
    mis(m_tag[1]);
    cyc(0, 0, 0, 0, 0, 0, 1);
    idle(3);

    // Wrap the tag space, then mispredict on a wrapped tag
    for (int i = 0; i < 20; i++) cyc(1, i, 64'h5000 + i, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    alloc(14, 64'hE0E0);
    alloc(15, 64'hF0F0);
    alloc(1, 64'h1010);
    mis(m_tag[1]);
    idle(3);

    // Commit together with a mispredict on the committing head
    alloc(2, 64'h2020);
    alloc(3, 64'h3030);
    cyc(0, 0, 0, 1, 1, m_tag[0], 0);
    idle(3);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      av = ($urandom_range(0, 99) < 55);
      cv = ($urandom_range(0, 99) < 30);
      mv = ($urandom_range(0, 99) < 10);
      fl = ($urandom_range(0, 99) < 3);
      if (m_tag.size() > 0 && $urandom_range(0, 3) != 0)
        mt = m_tag[$urandom_range(0, m_tag.size() - 1)];
      else
        mt = int'($urandom_range(0, DEPTH - 1));
      cyc(av, int'($urandom_range(0, 15)), {$urandom(), $urandom()}, cv, mv, mt, fl);
    end
    idle(3);

    @(negedge clock);
    #1;
    mon_en = 1'b0;
    chk("exp_queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
